// File: rtl/modulo_decodificador_bcd_pkg.sv
// Shared constants and state encoding for the signed-result BCD decoder.
package modulo_decodificador_bcd_pkg;

  localparam int LARG_RES = 9;
  localparam int BCD_W    = 4;
  localparam int N_ITER   = 9;
  localparam int CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CONVERTE = 2'd1,
    FIM      = 2'd2
  } estado_t;

endpackage

// File: rtl/modulo_decodificador_bcd_corrige.sv
// Double-dabble add-3 correction for one BCD digit.
module modulo_corrige_bcd
  import modulo_decodificador_bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digito,
  output logic [BCD_W-1:0] corrigido
);

  assign corrigido = (digito >= BCD_W'(5)) ? digito + BCD_W'(3) : digito;

endmodule

// File: rtl/modulo_decodificador_bcd.sv
// Converts the adder/subtractor result into sign plus three BCD digits
// with an iterative double-dabble; outputs only change in the done cycle.
module modulo_decodificador_bcd
  import modulo_decodificador_bcd_pkg::*;
#(
  parameter int LARG_RES = modulo_decodificador_bcd_pkg::LARG_RES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LARG_RES-1:0] resultado,
  input  logic                op,
  output logic                busy,
  output logic                done,
  output logic                negativo,
  output logic [BCD_W-1:0]    centenas,
  output logic [BCD_W-1:0]    dezenas,
  output logic [BCD_W-1:0]    unidades,
  output estado_t             estado
);

  // Handshake: start is accepted only on an edge where the FSM is IDLE;
  // done pulses for one cycle and the outputs are valid from that cycle.
  localparam int SR_W = 3*BCD_W + LARG_RES;

  logic [SR_W-1:0]     sr;
  logic [SR_W-1:0]     sr_corr;
  logic [CNT_W-1:0]    iter;
  logic                neg_q;
  logic [LARG_RES-1:0] mag;
  logic                mag_neg;
  logic [BCD_W-1:0]    c_corr;
  logic [BCD_W-1:0]    d_corr;
  logic [BCD_W-1:0]    u_corr;

  // A sum is always non-negative; a subtraction with bit 8 set is a borrow.
  always_comb begin
    mag_neg = op & resultado[LARG_RES-1];
    mag     = mag_neg ? (~resultado + LARG_RES'(1)) : resultado;
  end

  modulo_corrige_bcd u_corr_c (.digito(sr[SR_W-1 -: BCD_W]),          .corrigido(c_corr));
  modulo_corrige_bcd u_corr_d (.digito(sr[SR_W-BCD_W-1 -: BCD_W]),    .corrigido(d_corr));
  modulo_corrige_bcd u_corr_u (.digito(sr[LARG_RES +: BCD_W]),        .corrigido(u_corr));

  assign sr_corr = {c_corr, d_corr, u_corr, sr[LARG_RES-1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      estado   <= IDLE;
      iter     <= '0;
      sr       <= '0;
      neg_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      negativo <= 1'b0;
      centenas <= '0;
      dezenas  <= '0;
      unidades <= '0;
    end else begin
      done <= 1'b0;
      case (estado)
        IDLE: begin
          if (start) begin
            sr     <= {{(3*BCD_W){1'b0}}, mag};
            neg_q  <= mag_neg;
            iter   <= '0;
            busy   <= 1'b1;
            estado <= CONVERTE;
          end
        end
        CONVERTE: begin
          sr <= sr_corr << 1;
          if (iter == CNT_W'(N_ITER-1)) begin
            estado <= FIM;
          end else begin
            iter <= iter + CNT_W'(1);
          end
        end
        FIM: begin
          centenas <= sr[SR_W-1 -: BCD_W];
          dezenas  <= sr[SR_W-BCD_W-1 -: BCD_W];
          unidades <= sr[LARG_RES +: BCD_W];
          negativo <= neg_q;
          done     <= 1'b1;
          busy     <= 1'b0;
          iter     <= '0;
          estado   <= IDLE;
        end
        default: estado <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_decodificador_bcd.sv
// Directed bench for modulo_decodificador_bcd: latency, sign rules, ignore/hold/abort behaviour.
module tb_modulo_decodificador_bcd;
  import modulo_decodificador_bcd_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [8:0] resultado;
  logic       op;
  logic       busy;
  logic       done;
  logic       negativo;
  logic [3:0] centenas;
  logic [3:0] dezenas;
  logic [3:0] unidades;
  estado_t    estado;

  int vectors     = 0;
  int miscompares = 0;

  modulo_decodificador_bcd #(.LARG_RES(9)) dut (
    .clk(clk), .reset(reset), .start(start), .resultado(resultado), .op(op),
    .busy(busy), .done(done), .negativo(negativo),
    .centenas(centenas), .dezenas(dezenas), .unidades(unidades), .estado(estado)
  );

  always #5 clk = ~clk;

  // Pulse start for one edge, then wait (bounded) for done; lat counts edges after capture.
  task automatic run_conv(input logic [8:0] r, input logic o, output int lat, output int busy_drops);
    resultado = r;
    op        = o;
    start     = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    lat        = 0;
    busy_drops = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done !== 1'b1 && busy !== 1'b1) busy_drops++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; resultado = '0; op = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done} !== 2'b00) begin
      miscompares++; $display("FAIL reset_flags: busy/done=%b expected 00", {busy, done});
    end
    vectors++;
    if ({negativo, centenas, dezenas, unidades} !== 13'h0000) begin
      miscompares++; $display("FAIL reset_outputs: got %h expected 0000", {negativo, centenas, dezenas, unidades});
    end
    vectors++;
    if (estado !== IDLE) begin
      miscompares++; $display("FAIL reset_state: got %0d expected IDLE", estado);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_conversions;
    logic [8:0]  t_res [8] = '{9'd15, 9'd256, 9'h1FF, 9'h1FB, 9'h1FF, 9'd40, 9'h100, 9'd0};
    logic        t_op  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [12:0] t_exp [8] = '{13'h0015, 13'h0256, 13'h0511, 13'h1005, 13'h1001, 13'h0040, 13'h1256, 13'h0000};
    int lat;
    int drops;
    for (int i = 0; i < 8; i++) begin
      run_conv(t_res[i], t_op[i], lat, drops);
      vectors++;
      if (lat != 10) begin
        miscompares++; $display("FAIL conv%0d_latency: got %0d edges expected 10", i, lat);
      end
      vectors++;
      if (drops != 0) begin
        miscompares++; $display("FAIL conv%0d_busy_gap: busy low %0d cycles expected 0", i, drops);
      end
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++; $display("FAIL conv%0d_busy_at_done: got %b expected 0", i, busy);
      end
      vectors++;
      if ({negativo, centenas, dezenas, unidades} !== t_exp[i]) begin
        miscompares++; $display("FAIL conv%0d_value: got %h expected %h", i, {negativo, centenas, dezenas, unidades}, t_exp[i]);
      end
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0) begin
        miscompares++; $display("FAIL conv%0d_done_width: done=%b expected 0", i, done);
      end
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    int extra;
    resultado = 9'd100; op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    resultado = 9'd77; op = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    lat++; start = 1'b0;
    while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    vectors++;
    if (lat != 10) begin
      miscompares++; $display("FAIL ignore_latency: got %0d expected 10", lat);
    end
    vectors++;
    if ({negativo, centenas, dezenas, unidades} !== 13'h0100) begin
      miscompares++; $display("FAIL ignore_value: got %h expected 0100", {negativo, centenas, dezenas, unidades});
    end
    extra = 0;
    repeat (15) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) extra++; end
    vectors++;
    if (extra != 0) begin
      miscompares++; $display("FAIL ignore_no_queue: %0d active cycles expected 0", extra);
    end
  endtask

  task automatic test_change_input;
    int lat;
    resultado = 9'd123; op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; resultado = 9'h1F0; op = 1'b1; lat = 0;
    while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    vectors++;
    if ({negativo, centenas, dezenas, unidades} !== 13'h0123 || lat != 10) begin
      miscompares++; $display("FAIL change_input: got %h lat %0d expected 0123 lat 10", {negativo, centenas, dezenas, unidades}, lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int gap;
    resultado = 9'd321; op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    resultado = 9'd42; lat = 0;
    while (done !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    vectors++;
    if ({negativo, centenas, dezenas, unidades} !== 13'h0321 || lat != 10) begin
      miscompares++; $display("FAIL b2b_first: got %h lat %0d expected 0321 lat 10", {negativo, centenas, dezenas, unidades}, lat);
    end
    gap = 0;
    do begin @(posedge clk); #1; gap++; end while (done !== 1'b1 && gap < 40);
    start = 1'b0;
    vectors++;
    if (gap != 11) begin
      miscompares++; $display("FAIL b2b_period: got %0d cycles expected 11", gap);
    end
    vectors++;
    if ({negativo, centenas, dezenas, unidades} !== 13'h0042) begin
      miscompares++; $display("FAIL b2b_second: got %h expected 0042", {negativo, centenas, dezenas, unidades});
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, negativo, centenas, dezenas, unidades} !== {2'b00, 13'h0042}) begin
      miscompares++; $display("FAIL hold_outputs: got %h expected 0042 idle", {busy, done, negativo, centenas, dezenas, unidades});
    end
  endtask

  task automatic test_reset_abort;
    int lat;
    int drops;
    int pulses;
    resultado = 9'd200; op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({busy, done, negativo, centenas, dezenas, unidades} !== 15'h0000 || estado !== IDLE) begin
      miscompares++; $display("FAIL abort_outputs: got %h state %0d expected 0000 IDLE", {busy, done, negativo, centenas, dezenas, unidades}, estado);
    end
    reset = 1'b0; start = 1'b0;
    pulses = 0;
    repeat (15) begin @(posedge clk); #1; if (done === 1'b1) pulses++; end
    vectors++;
    if (pulses != 0) begin
      miscompares++; $display("FAIL abort_no_done: got %0d pulses expected 0", pulses);
    end
    run_conv(9'd37, 1'b0, lat, drops);
    vectors++;
    if ({negativo, centenas, dezenas, unidades} !== 13'h0037 || lat != 10) begin
      miscompares++; $display("FAIL after_abort: got %h lat %0d expected 0037 lat 10", {negativo, centenas, dezenas, unidades}, lat);
    end
  endtask

  initial begin
    test_reset();
    test_conversions();
    test_ignore_start();
    test_change_input();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
